instr_mem_sync: RTL and testbench
=================================

# instr_mem_sync

Parametrised, synchronous instruction memory for the 6-stage pipeline, replacing the fixed 16-entry combinational ROM at the fetch stage. It adds a registered fetch output with stall/flush control and tags each word with its PC. Out-of-range and misaligned fetches return a NOP with fault flags. A boot-load mode lets a test bench or loader write the program at run time through a word-write port.

## Interface
- DATA_W, 16, instruction width
- DEPTH, 64, words of storage; power of two, 2..4096
- AW, log2(DEPTH), word-address width (derived; never overridden)
- NOP_WORD, 16'h0000, word returned for invalid, faulted or flushed fetches

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- pc  in  16  byte address of fetch; word index = pc[AW:1]
- fetch_en  in  1  fetch request this cycle
- stall  in  1  hold all fetch outputs
- flush  in  1  kill the output word; priority over stall
- prog_en  in  1  request and hold load mode
- prog_we  in  1  write strobe, honoured only in LOAD
- prog_addr  in  AW  word address of write
- prog_data  in  DATA_W  write data
- instr  out  DATA_W  registered instruction
- instr_pc  out  16  pc that produced instr
- instr_valid  out  1  instr is a real fetched word
- fault  out  2  bit0 out-of-range (pc >= 2*DEPTH), bit1 misaligned (pc[0]=1)
- ready  out  1  1 in RUN state
- prog_cnt  out  AW+1  writes accepted in current/last load session, saturating at DEPTH

## Operation
- Storage: DEPTH x DATA_W array. It is not cleared by rst. Contents persist across reset and state changes.
- FSM states RUN, DRAIN, LOAD; reset state RUN.
  - RUN: prog_en=1 -> DRAIN, otherwise stay.
  - DRAIN: one cycle, then -> LOAD unconditionally (even if prog_en has dropped).
  - LOAD: prog_en=0 -> RUN, otherwise stay.
- Fetch accepted when state=RUN, fetch_en=1, stall=0, flush=0. At the next edge:
  - instr_pc <= pc.
  - instr <= mem[pc[AW:1]] if no fault, else NOP_WORD.
  - fault <= {misaligned, out_of_range}.
  - instr_valid <= ~|fault.
- Both faults may set together; then instr = NOP_WORD and instr_valid = 0.
- RUN, fetch_en=0, no stall/flush: instr <= NOP_WORD, instr_valid <= 0, fault <= 0, instr_pc holds.
- stall=1 (flush=0): instr, instr_pc, instr_valid and fault all hold; pc is ignored.
- flush=1: instr <= NOP_WORD, instr_valid <= 0, fault <= 0, in any state, regardless of stall or fetch_en.
- DRAIN and LOAD: fetch outputs forced as in the flush case every cycle. ready=0.
- Load writes: in LOAD, prog_we=1 -> mem[prog_addr] <= prog_data, and prog_cnt increments (saturating at DEPTH).
  - prog_cnt clears to 0 on the RUN->DRAIN transition.
  - prog_cnt holds its value in RUN.
  - prog_we outside LOAD is ignored and does not count.
- Writes to the same address overwrite; each write counts.
- Reset mid-load: the FSM returns to RUN. Writes already committed remain in memory. prog_cnt clears.

## Timing
- Reset values: instr=NOP_WORD, instr_pc=0, instr_valid=0, fault=0, ready=1, prog_cnt=0, state=RUN.
- Fetch latency: 1 cycle; pc presented at edge N appears on instr at edge N+1. Throughput one word/cycle.
- Stall: outputs are frozen for every stalled cycle. The first unstalled cycle samples the then-current pc.
- Load entry: prog_en sampled high at edge N. DRAIN after N, LOAD after N+1. The first write is accepted at edge N+2. ready falls after N.
- Load exit: prog_en low at edge M -> RUN after M, ready=1 after M. A write with prog_we=1 at edge M is still committed (state was LOAD).
- The first fetch after a load can target any address written in LOAD, including the one written in the final LOAD cycle. New data is returned.
- The memory read is in the same edge as the registered output. No read-during-write case exists, because writes occur only outside RUN.

## Test plan
- Reset, then LOAD: prog_en=1 for 2+20 cycles, writing words 0..19 with 16'h1000+i. Drop prog_en -> prog_cnt=20, ready=1.
- Fetch pc=0,2,...,38 back-to-back -> instr=16'h1000..16'h1013 one cycle later, instr_pc matching, instr_valid=1 each cycle.
- With DEPTH=64: pc=16'h0080 -> instr=0, fault=2'b01, valid=0. pc=16'h0003 -> fault=2'b10. pc=16'h0081 -> fault=2'b11.
- Fetch pc=4 then stall 3 cycles with pc changing -> instr holds 16'h1002. Next, flush with stall=1 -> instr=0, valid=0.
- Assert rst mid-LOAD after 5 writes to addresses 0..4 with 16'hBEEF -> ready=1, prog_cnt=0. A fetch of pc=8 returns 16'hBEEF.
- In RUN, prog_we=1 to address 3 with 16'hDEAD -> no change; pc=6 still returns the prior word. Also test 70 writes in LOAD with DEPTH=64 -> prog_cnt=64 (saturated).

Source files
------------

// File: rtl/instr_mem_sync_if.sv
// Fetch/program bus between the pipeline (or a loader) and instr_mem_sync.
interface instr_mem_sync_if #(
  parameter int DATA_W = 16,
  parameter int AW     = 6
);
  logic [15:0]       pc;
  logic              fetch_en;
  logic              stall;
  logic              flush;
  logic              prog_en;
  logic              prog_we;
  logic [AW-1:0]     prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [DATA_W-1:0] instr;
  logic [15:0]       instr_pc;
  logic              instr_valid;
  logic [1:0]        fault;
  logic              ready;
  logic [AW:0]       prog_cnt;

  // Fetch stage / loader side
  modport master (
    output pc, fetch_en, stall, flush, prog_en, prog_we, prog_addr, prog_data,
    input  instr, instr_pc, instr_valid, fault, ready, prog_cnt
  );

  // Memory side
  modport slave (
    input  pc, fetch_en, stall, flush, prog_en, prog_we, prog_addr, prog_data,
    output instr, instr_pc, instr_valid, fault, ready, prog_cnt
  );
endinterface

// File: rtl/instr_mem_sync.sv
// Synchronous instruction memory with registered fetch output, stall/flush,
// PC tagging, range/alignment faults and a run-time boot-load mode.
module instr_mem_sync #(
  parameter int              DATA_W   = 16,
  parameter int              DEPTH    = 64,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic            clk,
  input  logic            rst,
  instr_mem_sync_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [15:0]       instr_pc_q, instr_pc_d;
  logic              valid_q, valid_d;
  logic [1:0]        fault_q, fault_d;
  logic [AW:0]       cnt_q, cnt_d;

  // Fault decode: word index is pc[AW:1], anything above it is out of range.
  logic oor, mis;
  assign oor = |bus.pc[15:AW+1];
  assign mis = bus.pc[0];

  // Storage is never reset; writes only land while in LOAD.
  always_ff @(posedge clk) begin
    if (state_q == LOAD && bus.prog_we) mem[bus.prog_addr] <= bus.prog_data;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      instr_q    <= NOP_WORD;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      fault_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
    end
  end

  // Mode sequencing: DRAIN is a single bubble cycle before LOAD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.prog_en) state_d = DRAIN;
      DRAIN:   state_d = LOAD;
      LOAD:    if (!bus.prog_en) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Load-session write counter: cleared on entry, saturates at DEPTH.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == RUN && bus.prog_en)                        cnt_d = '0;
    else if (state_q == LOAD && bus.prog_we && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  // Fetch output: flush/non-RUN kill, stall freezes, otherwise fetch or bubble.
  always_comb begin
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    if (bus.flush || state_q != RUN) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      fault_d = '0;
    end else if (!bus.stall) begin
      if (bus.fetch_en) begin
        instr_pc_d = bus.pc;
        fault_d    = {mis, oor};
        valid_d    = ~(mis | oor);
        instr_d    = (mis | oor) ? NOP_WORD : mem[bus.pc[AW:1]];
      end else begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
        fault_d = '0;
      end
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.fault       = fault_q;
  assign bus.ready       = (state_q == RUN);
  assign bus.prog_cnt    = cnt_q;
endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed bench for instr_mem_sync (DEPTH=64): load, fetch, faults,
// stall/flush, reset mid-load, ignored RUN writes and counter saturation.
module tb_instr_mem_sync;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 64;
  localparam int AW     = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_mem_sync_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

  instr_mem_sync #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NOP_WORD(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [15:0] p);
    bus.pc = p; bus.fetch_en = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
    tick();
  endtask

  initial begin
    bus.pc = '0; bus.fetch_en = 0; bus.stall = 0; bus.flush = 0;
    bus.prog_en = 0; bus.prog_we = 0; bus.prog_addr = '0; bus.prog_data = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    // reset state
    chk("rst_instr", 32'(bus.instr), 32'h0);
    chk("rst_pc", 32'(bus.instr_pc), 32'h0);
    chk("rst_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_fault", 32'(bus.fault), 32'h0);
    chk("rst_ready", 32'(bus.ready), 32'h1);
    chk("rst_cnt", 32'(bus.prog_cnt), 32'h0);

    // load 20 words; fetch_en held high to confirm outputs are forced to NOP
    bus.prog_en = 1; bus.fetch_en = 1; bus.pc = 16'h0000;
    tick();
    chk("drain_ready", 32'(bus.ready), 32'h0);
    tick();
    for (int i = 0; i < 20; i++) begin
      bus.prog_we = 1; bus.prog_addr = AW'(i); bus.prog_data = 16'(16'h1000 + i);
      if (i == 19) bus.prog_en = 0;   // write on the exit edge still commits
      tick();
      if (i == 0) chk("load_valid", 32'(bus.instr_valid), 32'h0);
    end
    bus.prog_we = 0; bus.fetch_en = 0;
    chk("load_cnt", 32'(bus.prog_cnt), 32'd20);
    chk("load_ready", 32'(bus.ready), 32'h1);

    // back-to-back fetch
    for (int i = 0; i < 20; i++) begin
      fetch(16'(2 * i));
      chk("fetch_instr", 32'(bus.instr), 32'(16'h1000 + i));
      chk("fetch_pc", 32'(bus.instr_pc), 32'(2 * i));
      chk("fetch_valid", 32'(bus.instr_valid), 32'h1);
    end

    // faults
    fetch(16'h0080);
    chk("oor_instr", 32'(bus.instr), 32'h0);
    chk("oor_fault", 32'(bus.fault), 32'h1);
    chk("oor_valid", 32'(bus.instr_valid), 32'h0);
    chk("oor_pc", 32'(bus.instr_pc), 32'h80);
    fetch(16'h0003);
    chk("mis_fault", 32'(bus.fault), 32'h2);
    chk("mis_instr", 32'(bus.instr), 32'h0);
    fetch(16'h0081);
    chk("both_fault", 32'(bus.fault), 32'h3);
    chk("both_valid", 32'(bus.instr_valid), 32'h0);

    // idle fetch: bubble, pc held
    bus.fetch_en = 0; bus.pc = 16'h0010;
    tick();
    chk("idle_fault", 32'(bus.fault), 32'h0);
    chk("idle_valid", 32'(bus.instr_valid), 32'h0);
    chk("idle_pc", 32'(bus.instr_pc), 32'h81);

    // stall holds, flush overrides stall
    fetch(16'h0004);
    chk("pre_stall", 32'(bus.instr), 32'h1002);
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      bus.pc = 16'(10 + 2 * i);
      tick();
      chk("stall_instr", 32'(bus.instr), 32'h1002);
      chk("stall_pc", 32'(bus.instr_pc), 32'h4);
      chk("stall_valid", 32'(bus.instr_valid), 32'h1);
    end
    bus.flush = 1;
    tick();
    chk("flush_instr", 32'(bus.instr), 32'h0);
    chk("flush_valid", 32'(bus.instr_valid), 32'h0);
    chk("flush_pc", 32'(bus.instr_pc), 32'h4);
    fetch(16'h0006);
    chk("post_flush", 32'(bus.instr), 32'h1003);

    // write strobe in RUN is ignored
    bus.fetch_en = 0; bus.prog_we = 1; bus.prog_addr = 6'd3; bus.prog_data = 16'hDEAD;
    tick();
    bus.prog_we = 0;
    chk("run_we_cnt", 32'(bus.prog_cnt), 32'd20);
    fetch(16'h0006);
    chk("run_we_data", 32'(bus.instr), 32'h1003);

    // reset mid-load; a write strobe during DRAIN must not land
    bus.fetch_en = 0; bus.prog_en = 1;
    tick();
    chk("drain2_ready", 32'(bus.ready), 32'h0);
    bus.prog_we = 1; bus.prog_addr = 6'd10; bus.prog_data = 16'hAAAA;
    tick();
    chk("drain_we_cnt", 32'(bus.prog_cnt), 32'h0);
    for (int i = 0; i < 5; i++) begin
      bus.prog_addr = AW'(i); bus.prog_data = 16'hBEEF;
      tick();
    end
    chk("mid_cnt", 32'(bus.prog_cnt), 32'd5);
    bus.prog_we = 0; bus.prog_en = 0;
    rst = 1;
    #1;
    chk("rst_load_ready", 32'(bus.ready), 32'h1);
    chk("rst_load_cnt", 32'(bus.prog_cnt), 32'h0);
    tick();
    rst = 0;
    tick();
    fetch(16'h0008);
    chk("beef", 32'(bus.instr), 32'hBEEF);
    fetch(16'h000A);
    chk("keep5", 32'(bus.instr), 32'h1005);
    fetch(16'h0014);
    chk("drain_ignored", 32'(bus.instr), 32'h100A);

    // saturation: 70 writes wrap the address, counter stops at DEPTH
    bus.fetch_en = 0; bus.prog_en = 1;
    tick(); tick();
    for (int i = 0; i < 70; i++) begin
      bus.prog_we = 1; bus.prog_addr = AW'(i % 64); bus.prog_data = 16'(16'h2000 + i);
      tick();
    end
    bus.prog_we = 0;
    chk("sat_cnt", 32'(bus.prog_cnt), 32'd64);
    bus.prog_en = 0;
    tick();
    chk("sat_ready", 32'(bus.ready), 32'h1);
    chk("sat_hold", 32'(bus.prog_cnt), 32'd64);
    fetch(16'h0000);
    chk("sat_w0", 32'(bus.instr), 32'h2040);
    fetch(16'h000A);
    chk("sat_w5", 32'(bus.instr), 32'h2045);
    fetch(16'h000C);
    chk("sat_w6", 32'(bus.instr), 32'h2006);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
